// File: rtl/gf_mult_arbiter_if.sv
// Bundles the request, response and arithmetic-unit connections of gf_mult_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface gf_mult_arbiter_if #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned IO_WIDTH = 8
);
    localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]          req_valid_i;
    logic [NUM_REQ-1:0]          req_ready_o;
    logic [NUM_REQ*IO_WIDTH-1:0] req_op_a_i;
    logic [NUM_REQ*IO_WIDTH-1:0] req_op_b_i;
    logic [NUM_REQ*IO_WIDTH-1:0] req_op_c_i;
    logic [NUM_REQ*2-1:0]        req_op_sel_i;

    logic                        rsp_valid_o;
    logic                        rsp_ready_i;
    logic [IO_WIDTH-1:0]         rsp_data_o;
    logic [IdW-1:0]              rsp_id_o;
    logic                        rsp_err_o;

    logic                        mult_trigger_o;
    logic [IO_WIDTH-1:0]         mult_op_a_o;
    logic [IO_WIDTH-1:0]         mult_op_b_o;
    logic [IO_WIDTH-1:0]         mult_op_c_o;
    logic [1:0]                  mult_op_sel_o;
    logic                        mult_busy_i;
    logic [IO_WIDTH-1:0]         mult_result_i;

    modport slave (
        input  req_valid_i, req_op_a_i, req_op_b_i, req_op_c_i, req_op_sel_i,
        output req_ready_o,
        output rsp_valid_o, rsp_data_o, rsp_id_o, rsp_err_o,
        input  rsp_ready_i,
        output mult_trigger_o, mult_op_a_o, mult_op_b_o, mult_op_c_o, mult_op_sel_o,
        input  mult_busy_i, mult_result_i
    );

    modport master (
        output req_valid_i, req_op_a_i, req_op_b_i, req_op_c_i, req_op_sel_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_data_o, rsp_id_o, rsp_err_o,
        output rsp_ready_i,
        input  mult_trigger_o, mult_op_a_o, mult_op_b_o, mult_op_c_o, mult_op_sel_o,
        output mult_busy_i, mult_result_i
    );
endinterface

// File: rtl/gf_mult_arbiter.sv
// Round-robin sharing of one GF(2^8) unit between NUM_REQ requesters, with a
// hang timeout while waiting for the unit's PENDING->IDLE sequence.
module gf_mult_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned IO_WIDTH = 8,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    gf_mult_arbiter_if.slave  bus
);
    localparam int unsigned IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [1:0]  OpRsvd = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e              state_q;
    logic [IdW-1:0]      ptr_q, ptr_d, id_q, grant_id;
    logic [CntW-1:0]     cnt_q;
    logic                seen_busy_q, trigger_q, rsp_valid_q, rsp_err_q;
    logic [IO_WIDTH-1:0] op_a_q, op_b_q, op_c_q, rsp_data_q;
    logic [1:0]          op_sel_q;
    logic [NUM_REQ-1:0]  rot_valid;
    logic                grant_vld, req_fire;
    logic [IO_WIDTH-1:0] grant_a, grant_b, grant_c;
    logic [1:0]          grant_sel;
    int                  pos;

    // Rotate valids so bit 0 is the pointer position; first set bit wins.
    always_comb begin
        rot_valid = NUM_REQ'({bus.req_valid_i, bus.req_valid_i} >> ptr_q);
        grant_vld = 1'b0;
        grant_id  = '0;
        pos       = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!grant_vld && rot_valid[k]) begin
                grant_vld = 1'b1;
                pos       = int'(ptr_q) + k;
                if (pos >= int'(NUM_REQ)) pos = pos - int'(NUM_REQ);
                grant_id  = IdW'(pos);
            end
        end
        grant_a   = '0;
        grant_b   = '0;
        grant_c   = '0;
        grant_sel = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (grant_id == IdW'(k)) begin
                grant_a   = bus.req_op_a_i[k*IO_WIDTH +: IO_WIDTH];
                grant_b   = bus.req_op_b_i[k*IO_WIDTH +: IO_WIDTH];
                grant_c   = bus.req_op_c_i[k*IO_WIDTH +: IO_WIDTH];
                grant_sel = bus.req_op_sel_i[k*2 +: 2];
            end
        end
        ptr_d    = (grant_id == IdW'(NUM_REQ - 1)) ? '0 : grant_id + IdW'(1);
        req_fire = (state_q == IDLE) && grant_vld && !rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            seen_busy_q <= 1'b0;
            trigger_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_c_q      <= '0;
            op_sel_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_fire) begin
                        op_a_q   <= grant_a;
                        op_b_q   <= grant_b;
                        op_c_q   <= grant_c;
                        op_sel_q <= grant_sel;
                        id_q     <= grant_id;
                        ptr_q    <= ptr_d;
                        if (grant_sel == OpRsvd) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                        end else begin
                            state_q   <= ISSUE;
                            trigger_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    trigger_q   <= 1'b0;
                    seen_busy_q <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (bus.mult_busy_i) seen_busy_q <= 1'b1;
                    // Completion is checked first so it wins over a same-cycle timeout.
                    if (!bus.mult_busy_i && seen_busy_q) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= bus.mult_result_i;
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o    = req_fire ? (NUM_REQ'(1) << grant_id) : '0;
    assign bus.rsp_valid_o    = rsp_valid_q;
    assign bus.rsp_data_o     = rsp_data_q;
    assign bus.rsp_id_o       = id_q;
    assign bus.rsp_err_o      = rsp_err_q;
    assign bus.mult_trigger_o = trigger_q;
    assign bus.mult_op_a_o    = op_a_q;
    assign bus.mult_op_b_o    = op_b_q;
    assign bus.mult_op_c_o    = op_c_q;
    assign bus.mult_op_sel_o  = op_sel_q;

endmodule
